// File: rtl/bcid_pkg.sv
// Shared types and helpers for the time-tagged hit buffer.
// Default widths match the standard BCID counter configuration.
package bcid_pkg;

    localparam int BCID_WIDTH_DEFAULT = 9;
    localparam int TOT_WIDTH_DEFAULT  = 4;

    typedef struct packed {
        logic [BCID_WIDTH_DEFAULT-1:0] bcid;
        logic [TOT_WIDTH_DEFAULT-1:0]  tot;
    } hit_t;

    // Modular distance from tag b to reference a; MSB set means b is still in the future.
    function automatic logic [BCID_WIDTH_DEFAULT-1:0] bcid_age(
        input logic [BCID_WIDTH_DEFAULT-1:0] a,
        input logic [BCID_WIDTH_DEFAULT-1:0] b
    );
        return a - b;
    endfunction

endpackage

// File: rtl/hit_fifo.sv
// Circular buffer with registered full/empty flags derived from the start-of-cycle count.
// Push while full and pop while empty are ignored.
module hit_fifo
    import bcid_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = hit_t
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;
    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count_nxt;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_FULL);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/hit_latency_buffer.sv
// Tags hits with the master BCID, buffers them, and forwards only those whose BCID
// was triggered at the latency-delayed time; untriggered entries expire once past.
module hit_latency_buffer
    import bcid_pkg::*;
#(
    parameter int BCID_WIDTH = BCID_WIDTH_DEFAULT,
    parameter int TOT_WIDTH  = TOT_WIDTH_DEFAULT,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 8
)(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [BCID_WIDTH-1:0] BcidIn,
    input  logic [BCID_WIDTH-1:0] BcidLatency,
    input  logic                  HitValid,
    input  logic [TOT_WIDTH-1:0]  HitTot,
    input  logic                  Trigger,
    output logic                  HitOutValid,
    input  logic                  HitOutReady,
    output logic [BCID_WIDTH-1:0] HitOutBcid,
    output logic [TOT_WIDTH-1:0]  HitOutTot,
    output logic [CNT_WIDTH-1:0]  OverflowCnt,
    output logic [CNT_WIDTH-1:0]  DiscardCnt,
    output logic                  Empty,
    output logic                  Full
);

    typedef struct packed {
        logic [BCID_WIDTH-1:0] bcid;
        logic [TOT_WIDTH-1:0]  tot;
    } entry_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    entry_t                w_hit_in;
    entry_t                w_head;
    logic                  w_empty;
    logic                  w_full;
    logic [BCID_WIDTH-1:0] w_age;
    logic                  w_current;
    logic                  w_past;
    logic                  w_send;
    logic                  w_out_free;
    logic                  w_pop_send;
    logic                  w_discard;

    logic                  r_trig_valid;
    logic [BCID_WIDTH-1:0] r_trig_bcid;
    logic                  r_out_valid;
    entry_t                r_out;
    logic [CNT_WIDTH-1:0]  r_ovf_cnt;
    logic [CNT_WIDTH-1:0]  r_dis_cnt;

    assign w_hit_in = {BcidIn, HitTot};

    hit_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_push  (HitValid),
        .i_data  (w_hit_in),
        .i_pop   (w_pop_send || w_discard),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A same-cycle trigger at age zero counts as SEND, so a trigger never races expiry.
    assign w_age      = BcidLatency - w_head.bcid;
    assign w_current  = (w_age == '0);
    assign w_past     = !w_current && !w_age[BCID_WIDTH-1];
    assign w_send     = !w_empty && ((r_trig_valid && (w_head.bcid == r_trig_bcid))
                                     || (Trigger && w_current));
    assign w_out_free = !r_out_valid || HitOutReady;
    assign w_pop_send = w_send && w_out_free;
    assign w_discard  = !w_empty && w_past && !w_send;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_trig_valid <= 1'b0;
            r_trig_bcid  <= '0;
            r_out_valid  <= 1'b0;
            r_out        <= '0;
            r_ovf_cnt    <= '0;
            r_dis_cnt    <= '0;
        end else begin
            if (Trigger) begin
                r_trig_valid <= 1'b1;
                r_trig_bcid  <= BcidLatency;
            end
            if (w_pop_send) begin
                r_out_valid <= 1'b1;
                r_out       <= w_head;
            end else if (HitOutReady) begin
                r_out_valid <= 1'b0;
            end
            if (HitValid && w_full) r_ovf_cnt <= sat_inc(r_ovf_cnt);
            if (w_discard)          r_dis_cnt <= sat_inc(r_dis_cnt);
        end
    end

    assign HitOutValid = r_out_valid;
    assign HitOutBcid  = r_out.bcid;
    assign HitOutTot   = r_out.tot;
    assign OverflowCnt = r_ovf_cnt;
    assign DiscardCnt  = r_dis_cnt;
    assign Empty       = w_empty;
    assign Full        = w_full;

endmodule

// File: tb/tb_hit_latency_buffer.sv
// Bench for hit_latency_buffer: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the buffering rules.
module tb_hit_latency_buffer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [8:0] BcidIn;
    logic [8:0] BcidLatency;
    logic       HitValid;
    logic [3:0] HitTot;
    logic       Trigger;
    logic       HitOutValid;
    logic       HitOutReady;
    logic [8:0] HitOutBcid;
    logic [3:0] HitOutTot;
    logic [7:0] OverflowCnt;
    logic [7:0] DiscardCnt;
    logic       Empty;
    logic       Full;

    hit_latency_buffer #(
        .BCID_WIDTH (9),
        .TOT_WIDTH  (4),
        .DEPTH      (16),
        .CNT_WIDTH  (8)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .BcidIn      (BcidIn),
        .BcidLatency (BcidLatency),
        .HitValid    (HitValid),
        .HitTot      (HitTot),
        .Trigger     (Trigger),
        .HitOutValid (HitOutValid),
        .HitOutReady (HitOutReady),
        .HitOutBcid  (HitOutBcid),
        .HitOutTot   (HitOutTot),
        .OverflowCnt (OverflowCnt),
        .DiscardCnt  (DiscardCnt),
        .Empty       (Empty),
        .Full        (Full)
    );

    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: buffer contents as a queue of {bcid, tot} in arrival order.
    logic [12:0] m_q[$];
    bit          m_tv;
    int          m_tb;
    bit          m_ov;
    int          m_ob;
    int          m_ot;
    int          m_oc;
    int          m_dc;

    task automatic model_step();
        int  age;
        bit  send;
        bit  disc;
        bit  was_full;
        if (Reset) begin
            m_q.delete();
            m_tv = 0; m_tb = 0;
            m_ov = 0; m_ob = 0; m_ot = 0;
            m_oc = 0; m_dc = 0;
            return;
        end
        send = 0;
        disc = 0;
        was_full = (m_q.size() == 16);
        if (m_q.size() > 0) begin
            age = (int'(BcidLatency) - int'(m_q[0][12:4]) + 512) % 512;
            if ((m_tv && int'(m_q[0][12:4]) == m_tb) || (Trigger && age == 0))
                send = 1;
            else if (age != 0 && age < 256)
                disc = 1;
        end
        if (send && (!m_ov || HitOutReady)) begin
            m_ov = 1;
            m_ob = int'(m_q[0][12:4]);
            m_ot = int'(m_q[0][3:0]);
            void'(m_q.pop_front());
        end else if (HitOutReady) begin
            m_ov = 0;
        end
        if (disc) begin
            void'(m_q.pop_front());
            if (m_dc < 255) m_dc++;
        end
        if (HitValid) begin
            if (was_full) begin
                if (m_oc < 255) m_oc++;
            end else begin
                m_q.push_back({BcidIn, HitTot});
            end
        end
        if (Trigger) begin
            m_tv = 1;
            m_tb = int'(BcidLatency);
        end
    endtask

    task automatic cyc(input bit rst, input bit hv, input int bin, input int tot,
                       input int lat, input bit trg, input bit rdy);
        Reset       = rst;
        HitValid    = hv;
        BcidIn      = 9'(bin);
        HitTot      = 4'(tot);
        BcidLatency = 9'(lat);
        Trigger     = trg;
        HitOutReady = rdy;
        model_step();
        @(posedge Clk);
        #1;
        chk("out_valid", HitOutValid, m_ov);
        chk("out_bcid", HitOutBcid, m_ob);
        chk("out_tot", HitOutTot, m_ot);
        chk("overflow_cnt", OverflowCnt, m_oc);
        chk("discard_cnt", DiscardCnt, m_dc);
        chk("empty", Empty, m_q.size() == 0);
        chk("full", Full, m_q.size() == 16);
    endtask

    initial begin
        int lat;
        Reset = 1'b1; HitValid = 0; BcidIn = 0; HitTot = 0;
        BcidLatency = 0; Trigger = 0; HitOutReady = 1;

        // Scenario 1: trigger picks tag 10, tag 11 expires at latency 12
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("reset_empty", Empty, 1);
        chk("reset_valid", HitOutValid, 0);
        cyc(0, 1, 10, 3, 8, 0, 1);
        cyc(0, 1, 11, 5, 8, 0, 1);
        cyc(0, 0, 0, 0, 9, 0, 1);
        cyc(0, 0, 0, 0, 10, 1, 1);
        chk("s1_valid", HitOutValid, 1);
        chk("s1_bcid", HitOutBcid, 10);
        chk("s1_tot", HitOutTot, 3);
        cyc(0, 0, 0, 0, 11, 0, 1);
        cyc(0, 0, 0, 0, 12, 0, 1);
        cyc(0, 0, 0, 0, 12, 0, 1);
        chk("s1_discard", DiscardCnt, 1);

        // Scenarios 2 and 6: fill, overflow once, then keep pushing until saturation
        cyc(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) cyc(0, 1, 100, i, 50, 0, 1);
        chk("s2_full", Full, 1);
        chk("s2_overflow", OverflowCnt, 1);
        for (int i = 0; i < 300; i++) cyc(0, 1, 100, 1, 50, 0, 1);
        chk("s6_saturate", OverflowCnt, 255);

        // Scenario 3: tags across the 511 -> 0 wrap
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 510, 1, 509, 0, 1);
        cyc(0, 1, 511, 2, 509, 0, 1);
        cyc(0, 1, 0, 3, 509, 0, 1);
        cyc(0, 0, 0, 0, 510, 0, 1);
        cyc(0, 0, 0, 0, 511, 1, 1);
        cyc(0, 0, 0, 0, 511, 0, 1);
        chk("s3_bcid", HitOutBcid, 511);
        cyc(0, 0, 0, 0, 511, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 1);
        chk("s3_discard", DiscardCnt, 2);

        // Scenario 4: backpressure on three same-tag entries
        cyc(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 20, 7 + i, 19, 0, 1);
        cyc(0, 0, 0, 0, 20, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 21 + i, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 26 + i, 0, 1);
        chk("s4_discard", DiscardCnt, 0);

        // Scenario 5: reset with the output register and buffer occupied
        cyc(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) cyc(0, 1, 30, i, 29, 0, 1);
        cyc(0, 0, 0, 0, 30, 1, 0);
        cyc(0, 0, 0, 0, 30, 0, 0);
        cyc(1, 0, 0, 0, 30, 0, 0);
        chk("s5_valid", HitOutValid, 0);
        chk("s5_empty", Empty, 1);
        cyc(0, 1, 41, 6, 40, 0, 1);
        cyc(0, 0, 0, 0, 41, 1, 1);
        cyc(0, 0, 0, 0, 42, 0, 1);

        // Random traffic
        cyc(1, 0, 0, 0, 0, 0, 1);
        lat = $urandom_range(0, 511);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) != 0) lat = (lat + 1) % 512;
            cyc(($urandom_range(0, 999) == 0),
                ($urandom_range(0, 1) == 1),
                (lat + int'($urandom_range(0, 6))) % 512,
                int'($urandom_range(0, 15)),
                lat,
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) < 7));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
